// File: rtl/inst_fetch.sv
// inst_fetch: program-memory instruction issuer for the BittyPro datapath.
// Define PROG_LOAD_EN to add the load_we/load_addr/load_data write port.
module inst_fetch #(
  parameter int unsigned          DEPTH      = 16,
  parameter int unsigned          AW         = $clog2(DEPTH),
  parameter int unsigned          PROG_LEN   = DEPTH,
  parameter bit                   WRAP       = 1'b0,
  parameter logic [15:0]          IDLE_WORD  = 16'h0000,
  parameter logic [16*DEPTH-1:0]  INIT_IMAGE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          done,
`ifdef PROG_LOAD_EN
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
`endif
  output logic [15:0]   instruction,
  output logic [AW-1:0] pc,
  output logic          running,
  output logic          halted,
  output logic [15:0]   retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_e;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_fetch: DEPTH must be a power of two >= 2");
  end
  if (PROG_LEN < 1 || PROG_LEN > DEPTH) begin : g_bad_len
    $error("inst_fetch: PROG_LEN must be in 1..DEPTH");
  end

  state_e         state_q;
  logic [AW-1:0]  pc_q;
  logic [15:0]    instr_q;
  logic [15:0]    retired_q;
  logic           running_q;
  logic           halted_q;

  // Word i of the image sits at bits [16*i +: 16].
  logic [DEPTH-1:0][15:0] mem;
  logic [15:0]            word0;

`ifdef PROG_LOAD_EN
  logic [DEPTH-1:0][15:0] mem_q = INIT_IMAGE;
  logic                   ld_ok;

  assign ld_ok = load_we && (state_q != S_RUN);

  // Program memory survives reset on purpose.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign mem   = mem_q;
  assign word0 = (ld_ok && load_addr == '0) ? load_data : mem_q[0];
`else
  localparam logic [DEPTH-1:0][15:0] ROM = INIT_IMAGE;

  assign mem   = ROM;
  assign word0 = ROM[0];
`endif

  logic [AW-1:0] pc_inc;
  logic          last;
  logic [15:0]   ret_inc;

  assign pc_inc  = pc_q + AW'(1);
  assign last    = (pc_q == AW'(PROG_LEN - 1));
  assign ret_inc = (retired_q == 16'hFFFF) ? retired_q
                                           : retired_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= IDLE_WORD;
      retired_q <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q   <= S_RUN;
            pc_q      <= '0;
            instr_q   <= word0;
            retired_q <= '0;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (done) begin
            retired_q <= ret_inc;
            if (!last) begin
              pc_q    <= pc_inc;
              instr_q <= mem[pc_inc];
            end else if (WRAP) begin
              pc_q    <= '0;
              instr_q <= mem[0];
            end else begin
              state_q   <= S_HALT;
              instr_q   <= IDLE_WORD;
              running_q <= 1'b0;
              halted_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          pc_q      <= '0;
          instr_q   <= IDLE_WORD;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with halt, wrap and
// single-word-wrap instances sharing one set of control inputs.
module tb_inst_fetch;

  localparam int unsigned D  = 16;
  localparam int unsigned AW = 4;
  localparam logic [16*D-1:0] IMG =
    {176'h0, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

  logic clk = 1'b0;
  logic reset, start, done;

  logic [15:0]   n_instr, w_instr, o_instr;
  logic [AW-1:0] n_pc, w_pc, o_pc;
  logic          n_run, w_run, o_run;
  logic          n_hlt, w_hlt, o_hlt;
  logic [15:0]   n_ret, w_ret, o_ret;

`ifdef PROG_LOAD_EN
  logic          load_we   = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
`endif

  always #5 clk = ~clk;

  inst_fetch #(.DEPTH(D), .PROG_LEN(4), .WRAP(1'b0),
               .INIT_IMAGE(IMG)) u_nw (
    .clk(clk), .reset(reset), .start(start), .done(done),
`ifdef PROG_LOAD_EN
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
`endif
    .instruction(n_instr), .pc(n_pc), .running(n_run),
    .halted(n_hlt), .retired(n_ret)
  );

  inst_fetch #(.DEPTH(D), .PROG_LEN(4), .WRAP(1'b1),
               .INIT_IMAGE(IMG)) u_wr (
    .clk(clk), .reset(reset), .start(start), .done(done),
`ifdef PROG_LOAD_EN
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
`endif
    .instruction(w_instr), .pc(w_pc), .running(w_run),
    .halted(w_hlt), .retired(w_ret)
  );

  inst_fetch #(.DEPTH(D), .PROG_LEN(1), .WRAP(1'b1),
               .INIT_IMAGE(IMG)) u_one (
    .clk(clk), .reset(reset), .start(start), .done(done),
`ifdef PROG_LOAD_EN
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
`endif
    .instruction(o_instr), .pc(o_pc), .running(o_run),
    .halted(o_hlt), .retired(o_ret)
  );

  int n_tot = 0;
  int n_bad = 0;
  logic [15:0] W [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    done  = 1'b0;
    repeat (3) tick();
    check("rst_instr", n_instr, 16'h0000);
    check("rst_hlt", n_hlt, 1'b0);
    reset = 1'b0;

    // idle 10 cycles with no start, done ignored
    repeat (5) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (4) tick();
    check("idle_instr", n_instr, 16'h0000);
    check("idle_pc", n_pc, 0);
    check("idle_run", n_run, 1'b0);
    check("idle_ret", n_ret, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("st_run", n_run, 1'b1);
    check("st_ret", n_ret, 0);

    // done every third cycle, six times
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        check("nw_pc", n_pc, k);
        check("nw_instr", n_instr, W[k]);
      end
      check("wr_pc", w_pc, k % 4);
      check("wr_instr", w_instr, W[k % 4]);
      check("one_ret", o_ret, k);
      tick();
      tick();
      if (k < 4) check("nw_hold", n_instr, W[k]);
      check("one_pc", o_pc, 0);
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    check("nw_hlt", n_hlt, 1'b1);
    check("nw_run", n_run, 1'b0);
    check("nw_ret", n_ret, 4);
    check("nw_hinstr", n_instr, 16'h0000);
    check("nw_hpc", n_pc, 3);
    check("wr_pc6", w_pc, 2);
    check("wr_ret6", w_ret, 6);
    check("one_instr", o_instr, 16'h1111);
    check("one_ret6", o_ret, 6);

    // restart from HALT; running instances ignore start
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_pc", n_pc, 0);
    check("rs_ret", n_ret, 0);
    check("rs_instr", n_instr, 16'h1111);
    check("wr_ign_pc", w_pc, 2);
    check("wr_ign_ret", w_ret, 6);

    // back-to-back done, start coincides on the second cycle
    done = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      start = (i == 2);
      tick();
      if (i < 4) begin
        check("bb_pc", n_pc, i);
        check("bb_instr", n_instr, W[i]);
      end
      check("bb_wpc", w_pc, (2 + i) % 4);
      check("bb_winstr", w_instr, W[(2 + i) % 4]);
    end
    done  = 1'b0;
    start = 1'b0;
    check("bb_hlt", n_hlt, 1'b1);
    check("bb_ret", n_ret, 4);
    check("bb_wret", w_ret, 10);
    check("bb_oret", o_ret, 10);

    // reset mid-run at pc=2
    start = 1'b1;
    tick();
    start = 1'b0;
    done = 1'b1;
    tick();
    tick();
    done = 1'b0;
    check("mr_pc2", n_pc, 2);
    reset = 1'b1;
    #1;
    check("mr_instr", n_instr, 16'h0000);
    check("mr_pc", n_pc, 0);
    check("mr_run", n_run, 1'b0);
    check("mr_ret", n_ret, 0);
    check("mr_wpc", w_pc, 0);
    check("mr_oret", o_ret, 0);
    tick();
    reset = 1'b0;
    tick();
    check("mr_idle", n_run, 1'b0);

    // retired saturation on the single-word wrap instance
    start = 1'b1;
    tick();
    start = 1'b0;
    done = 1'b1;
    repeat (65540) tick();
    done = 1'b0;
    tick();
    check("sat_ret", o_ret, 16'hFFFF);
    check("sat_pc", o_pc, 0);
    check("sat_instr", o_instr, 16'h1111);
    check("sat_nhlt", n_hlt, 1'b1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
